// File: rtl/bist_pkg.sv
// Shared types and constants for the 16-bit NOT-chip BIST engine.
// Vector order: fixed patterns, then walking ones, then Galois LFSR vectors.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] VEC_ZERO  = 16'h0000;
    localparam logic [15:0] VEC_ONES  = 16'hFFFF;
    localparam logic [15:0] VEC_PAT   = 16'hAB1A;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int FIXED_N = 3;
    localparam int WALK_N  = 16;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois right-shift LFSR; load beats en, reset reloads the seed.
// Latency: one cycle per step; no backpressure.
module lfsr16
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/not16_bist.sv
// BIST engine for a 16-bit NOT chip: drives vectors, checks out == ~in, reports results.
// Latency: 2 cycles per vector, done at edge 2*(19+N_LFSR)+1 after start; start ignored while busy.
module not16_bist
    import bist_pkg::*;
#(
    parameter int          WIDTH  = 16,
    parameter int          N_LFSR = 32,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] first_fail_vec
);

    localparam int         TOTAL    = FIXED_N + WALK_N + N_LFSR;
    localparam logic [8:0] LAST_IDX = 9'(TOTAL - 1);
    localparam logic [8:0] LFSR_IDX = 9'(FIXED_N + WALK_N);

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  vidx;
    logic        last_vec;
    logic        start_acc;
    logic        drive_en;
    logic        sample_en;
    logic        lfsr_en;
    logic        mismatch;
    logic [15:0] lfsr_q;
    logic [15:0] vec;

    assign last_vec = (vidx == LAST_IDX);
    assign mismatch = (dut_out != ~dut_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   if (start) state_nxt = ST_DRIVE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        start_acc = 1'b0;
        drive_en  = 1'b0;
        sample_en = 1'b0;
        lfsr_en   = 1'b0;
        case (state)
            ST_IDLE:   start_acc = start;
            ST_DRIVE: begin
                busy     = 1'b1;
                drive_en = 1'b1;
            end
            ST_SAMPLE: begin
                busy      = 1'b1;
                sample_en = 1'b1;
                // Step only when another LFSR vector follows in this run.
                lfsr_en   = !last_vec && (vidx >= LFSR_IDX);
            end
            ST_DONE:   start_acc = start;
            default:   busy = 1'b0;
        endcase
    end

    always_comb begin
        vec = lfsr_q;
        if (vidx < 9'(FIXED_N)) begin
            case (vidx[1:0])
                2'd0:    vec = VEC_ZERO;
                2'd1:    vec = VEC_ONES;
                default: vec = VEC_PAT;
            endcase
        end else if (vidx < LFSR_IDX) begin
            vec = 16'h0001 << (vidx - 9'(FIXED_N));
        end
    end

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .en    (lfsr_en),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in         <= '0;
            vidx           <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            done           <= 1'b0;
        end else if (start_acc) begin
            vidx           <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            done           <= 1'b0;
        end else begin
            // done trails entry to DONE by one cycle so a held start never flashes it.
            if (state == ST_DONE) done <= 1'b1;
            if (drive_en) dut_in <= vec;
            if (sample_en) begin
                if (mismatch) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0)  first_fail_vec <= dut_in;
                end
                if (!last_vec) vidx <= vidx + 9'd1;
            end
        end
    end

    assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_not16_bist.sv
// Scoreboard bench for not16_bist: vectors and run results predicted from the vector rules.
module tb_not16_bist;

    localparam int V_MAIN = 51;

    typedef struct {
        int          err;
        logic [15:0] ffv;
        int          done_edge;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dut_in, dut_out, first_fail_vec;
    logic        busy, done, pass;
    logic [7:0]  err_count;

    logic        s_start, s_busy, s_done, s_pass;
    logic [15:0] s_dut_in, s_dut_out, s_ffv;
    logic [7:0]  s_err;

    logic        b_start, b_busy, b_done, b_pass;
    logic [15:0] b_dut_in, b_dut_out, b_ffv;
    logic [7:0]  b_err;

    int          chip_mode;
    logic [15:0] chip_mask;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          vcnt = 0;
    logic        done_q = 1'b0;
    logic [15:0] vq[$];
    res_t        rq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] vec_at(input int idx);
        logic [15:0] v;
        if (idx == 0) return 16'h0000;
        if (idx == 1) return 16'hFFFF;
        if (idx == 2) return 16'hAB1A;
        if (idx < 19) return 16'(1 << (idx - 3));
        v = 16'hACE1;
        for (int i = 19; i < idx; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    function automatic logic [15:0] chip_model(input logic [15:0] v, input int mode,
                                               input logic [15:0] mask);
        case (mode)
            1:       return v;
            2:       return ~v | 16'h8000;
            3:       return (v[3:0] == mask[3:0]) ? (~v ^ mask) : ~v;
            default: return ~v;
        endcase
    endfunction

    assign dut_out   = chip_model(dut_in, chip_mode, chip_mask);
    assign s_dut_out = ~s_dut_in;
    assign b_dut_out = b_dut_in;

    not16_bist u_dut (
        .clk(clk), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec)
    );

    not16_bist #(.N_LFSR(3)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .dut_in(s_dut_in), .dut_out(s_dut_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_fail_vec(s_ffv)
    );

    not16_bist #(.N_LFSR(255)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .dut_in(b_dut_in), .dut_out(b_dut_out),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_fail_vec(b_ffv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: second busy cycle of every pair presents a vector; done rise closes a run.
    always @(negedge clk) begin
        res_t r;
        logic [15:0] ev;
        check("busy_and_done", {30'd0, busy, done} == 32'd3, 1'b0);
        if (reset || !busy) begin
            vcnt = 0;
        end else begin
            vcnt++;
            if (vcnt % 2 == 0) begin
                if (vq.size() == 0) begin
                    check("unexpected_vector", dut_in, 16'hxxxx);
                end else begin
                    ev = vq.pop_front();
                    check("dut_in_vector", dut_in, ev);
                end
            end
        end
        if (done && !done_q) begin
            if (rq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                r = rq.pop_front();
                check("err_count", err_count, r.err);
                check("first_fail_vec", first_fail_vec, r.ffv);
                check("pass", pass, r.err == 0);
                check("done_edge", cyc, r.done_edge);
            end
        end
        done_q = done;
    end

    task automatic expect_run(input int mode, input logic [15:0] mask,
                              output int err, output logic [15:0] ffv);
        logic [15:0] v;
        err = 0;
        ffv = 16'h0000;
        for (int i = 0; i < V_MAIN; i++) begin
            v = vec_at(i);
            vq.push_back(v);
            if (chip_model(v, mode, mask) != ~v) begin
                if (err == 0) ffv = v;
                if (err < 255) err++;
            end
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dut_in"}, dut_in, 16'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_err"}, err_count, 8'h0);
        check({tag, "_ffv"}, first_fail_vec, 16'h0);
    endtask

    task automatic run(input int mode, input logic [15:0] mask, input int abort_at);
        int          e, st;
        logic [15:0] f;
        chip_mode = mode;
        chip_mask = mask;
        expect_run(mode, mask, e, f);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        st = cyc;
        rq.push_back('{e, f, st + 2 * V_MAIN + 1});
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #2;
            reset = 1'b1;
            @(posedge clk); #2;
            check_reset_vals("abort");
            reset = 1'b0;
            vq.delete();
            void'(rq.pop_back());
        end else begin
            wait_done("run_timeout", 400);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2;
    endtask

    initial begin
        int          e, st, n;
        logic [15:0] f;
        reset = 1'b1; start = 1'b0; s_start = 1'b0; b_start = 1'b0;
        chip_mode = 0; chip_mask = 16'h0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #2;

        run(0, 16'h0, 0);
        run(1, 16'h0, 0);
        run(2, 16'h0, 0);
        run(0, 16'h0, 40);
        run(0, 16'h0, 0);
        for (int k = 0; k < 4; k++) run($urandom_range(0, 3), 16'($urandom_range(1, 65535)), 0);

        // start held for a whole run: relaunch straight from DONE without done rising
        chip_mode = 2;
        expect_run(2, 16'h0, e, f);
        expect_run(2, 16'h0, e, f);
        start = 1'b1;
        @(posedge clk); #2;
        st = cyc;
        rq.push_back('{e, f, st + 4 * V_MAIN + 2});
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        check("held_busy_fall", cyc, st + 2 * V_MAIN);
        check("held_done_low", done, 1'b0);
        @(posedge clk); #2;
        check("held_relaunch_busy", busy, 1'b1);
        check("held_relaunch_done", done, 1'b0);
        start = 1'b0;
        wait_done("held_timeout", 400);
        repeat (2) @(posedge clk);
        #2;

        // N_LFSR=3 instance: watch the LFSR phase and run length
        s_start = 1'b1;
        @(posedge clk); #2;
        s_start = 1'b0;
        st = cyc;
        for (int rel = 1; rel <= 45; rel++) begin
            @(posedge clk); #2;
            if (rel == 39 || rel == 41 || rel == 43)
                check("small_lfsr_vec", s_dut_in, vec_at(19 + (rel - 39) / 2));
            if (rel == 44) check("small_done_early", s_done, 1'b0);
        end
        check("small_done", s_done, 1'b1);
        check("small_pass", s_pass, 1'b1);
        check("small_err", s_err, 8'h0);

        // N_LFSR=255 identity chip: every vector fails, count saturates
        b_start = 1'b1;
        @(posedge clk); #2;
        b_start = 1'b0;
        st = cyc;
        n = 0;
        while (!b_done && n < 700) begin
            @(posedge clk); #2;
            n++;
        end
        check("big_done_edge", cyc, st + 2 * 274 + 1);
        check("big_err_sat", b_err, 8'hFF);
        check("big_ffv", b_ffv, 16'h0000);
        check("big_pass", b_pass, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", vq.size() + rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/not16_bist.md
# not16_bist

Synthesizable built-in self-test engine for the 16-bit NOT chip. It drives a fixed, repeatable vector sequence into the chip's `in` bus and samples its `out` bus. Each response is checked against the bitwise complement of the applied vector. The engine reports pass/fail, an error count and the first failing vector. It sits beside `not_16bit_chip` in the chips library as the on-silicon counterpart of the simulation bench, and is reusable for any 16-bit unary chip whose golden model is `~in`.

## Interface
Parameters:
- `WIDTH`, 16, data width of the vector buses. Only 16 is supported.
- `N_LFSR`, 32, number of pseudo-random vectors, 1..255.
- `SEED`, 16'hACE1, LFSR seed. Must be nonzero.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE or DONE.
- `dut_in`  out  16  vector driven into the chip under test.
- `dut_out`  in  16  response from the chip under test.
- `busy`  out  1  high during DRIVE and SAMPLE.
- `done`  out  1  high in DONE; stays high until the next `start` or `reset`.
- `pass`  out  1  equals `done && err_count==0`.
- `err_count`  out  8  number of mismatching vectors; saturates at 255.
- `first_fail_vec`  out  16  the first vector that mismatched; 0 if none.

## Operation
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
  - IDLE → DRIVE on `start`.
  - DRIVE → SAMPLE unconditionally.
  - SAMPLE → DRIVE if vectors remain, else → DONE.
  - DONE → DRIVE on `start`.
- Vector order (index `vidx`), total `3 + 16 + N_LFSR` vectors (51 by default):
  - Fixed phase, idx 0..2: 16'h0000, 16'hFFFF, 16'hAB1A.
  - Walking-ones phase, idx 3..18: 16'h0001 << (idx−3).
  - LFSR phase: the first LFSR vector is `SEED`. Each later vector is the previous one advanced one step by a Galois right-shift with tap mask 16'hB400: `lsb ? (v>>1)^16'hB400 : v>>1`.
- In DRIVE, the current vector is registered onto `dut_in`.
- In SAMPLE, `dut_out` is compared with `~dut_in`. On mismatch:
  - `err_count` increments, saturating at 255.
  - If this is the first error of the run, `dut_in` is latched into `first_fail_vec`.
- Accepting `start` (from IDLE or DONE) does all of the following:
  - clears `err_count`, `first_fail_vec` and `done`;
  - reloads the LFSR with `SEED`;
  - resets `vidx` to 0.
- `start` is ignored while `busy`.
- `dut_in` holds its last value in SAMPLE, DONE and IDLE, and is 0 after reset.

## Timing
- Reset values: state IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `vidx`=0, LFSR=`SEED`.
- `reset` wins over every other input in the same cycle. Asserting `reset` mid-run aborts the run and returns to the reset values on the next edge.
- Each vector takes 2 cycles: one DRIVE and one SAMPLE. The chip under test must settle combinationally within one clock period.
- Run latency: with `start` sampled at edge 0, vector k is on `dut_in` from edge 2k+1. `done` rises at edge 2·(19+N_LFSR)+1, which is edge 103 by default.
- `busy` and `done` are never high together.
- `start` asserted in DONE begins a new run: DRIVE on the next edge, with `done` low in that same cycle.
- `err_count` saturation: at 255, further mismatches are not counted. `first_fail_vec` is unaffected by saturation.
- The LFSR advances only on SAMPLE→DRIVE transitions within the LFSR phase.

## Structure
- Package `bist_pkg` holds:
  - the FSM state enum;
  - the fixed vector constants (16'h0000, 16'hFFFF, 16'hAB1A);
  - `LFSR_TAPS` = 16'hB400;
  - the phase boundary constants `FIXED_N`=3 and `WALK_N`=16.
- Sub-module `lfsr16`: inputs `clk`, `reset`, `load`, `en`, `seed[15:0]`; output `q[15:0]`. It has one-step Galois advance, and `load` has priority over `en`.
- Top-level block: the FSM, the vector mux selected by phase, the comparator and the result registers.

## Test plan
- Correct NOT model (`dut_out = ~dut_in`), `start` pulsed once → `done` at cycle 103, `pass`=1, `err_count`=0, `first_fail_vec`=0.
- Identity chip (`dut_out = dut_in`) → all 51 vectors fail: `err_count`=51, `first_fail_vec`=16'h0000, `pass`=0.
- NOT model with bit 15 stuck-at-1 → `first_fail_vec`=16'hFFFF, `err_count` ≥3 (vectors FFFF, AB1A and 8000 all fail), `pass`=0.
- `reset` asserted at cycle 40 mid-run, then `start` again → all outputs at reset values one edge later; the second run completes with identical results and timing.
- `start` held high for the whole run → it is ignored while `busy`. After `done`, the still-high `start` immediately launches a new run: `done` low for one edge, then `busy`.
- Monitor the LFSR phase with `N_LFSR`=3 → `dut_in` shows 16'hACE1, then 16'hE270, then 16'h7138. `done` at cycle 45.
